mem_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 10 +
 rtl/rd_tag_pipe.sv | 24 ++
 rtl/mem_arbiter.sv | 77 +++++++
 tb/tb_mem_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared owner/tag types and parameter limits for the memory arbiter.
package arb_pkg;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;
    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage shift register of read tags, aligned with memory read latency.
module rd_tag_pipe
    import arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);
    tag_t [DEPTH-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
        end
    end

    assign tag_out = q[DEPTH-1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, data-first with a
// bounded data streak, and routes each read response back to its owner.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int READ_LAT        = 1,
    parameter int MAX_DATA_STREAK = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX || MAX_DATA_STREAK < 1) begin : g_bad_param
        $error("mem_arbiter: illegal READ_LAT or MAX_DATA_STREAK");
    end

    logic [SW-1:0] streak;
    logic          fetch_turn;
    tag_t          tag_in;
    tag_t          tag_out;

    // Fetch wins when alone or once data has used up its streak allowance.
    assign fetch_turn = if_req && (!d_req || streak == SMAX);
    assign if_gnt     = !rst && fetch_turn;
    assign d_gnt      = !rst && d_req && !fetch_turn;

    always_ff @(posedge clk) begin
        if (rst || !if_req || if_gnt) streak <= '0;
        else if (d_gnt && streak != SMAX) streak <= streak + 1'b1;
    end

    always_comb begin
        mem_en    = if_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = if_gnt ? if_addr : d_gnt ? d_addr : '0;
        mem_wdata = d_gnt ? d_wdata : '0;
        mem_be    = if_gnt ? '1 : d_gnt ? d_be : '0;
    end

    assign tag_in = '{valid: if_gnt || (d_gnt && !d_we), owner: if_gnt ? OWN_IF : OWN_D};

    rd_tag_pipe #(.DEPTH(READ_LAT)) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    // Responses of reads issued before a reset are dropped even while rst is high.
    assign if_rvalid = !rst && tag_out.valid && tag_out.owner == OWN_IF;
    assign d_rvalid  = !rst && tag_out.valid && tag_out.owner == OWN_D;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiters (READ_LAT 1,2,3) share stimulus; checked against a
// grant-history model, a vector table, directed corner sequences and random traffic.
module tb_mem_arbiter;
    localparam int AW = 32, DW = 32, BW = DW/8, MAXS = 2, NI = 3;

    logic          clk = 1'b0;
    logic          rst, if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [BW-1:0] d_be;
    logic          if_gnt [NI], if_rvalid [NI], d_gnt [NI], d_rvalid [NI], mem_en [NI], mem_we [NI];
    logic [DW-1:0] if_rdata [NI], d_rdata [NI], mem_wdata [NI];
    logic [AW-1:0] mem_addr [NI];
    logic [BW-1:0] mem_be [NI];

    int checks = 0, errors = 0, cyc_n = 0;
    int wait_n = 0, last_rst = -1;
    int hist [int];
    logic eg_if = 1'b0, eg_d = 1'b0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(k + 1), .MAX_DATA_STREAK(MAXS)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[k]),
            .if_rvalid(if_rvalid[k]), .if_rdata(if_rdata[k]),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
            .d_gnt(d_gnt[k]), .d_rvalid(d_rvalid[k]), .d_rdata(d_rdata[k]),
            .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
            .mem_wdata(mem_wdata[k]), .mem_be(mem_be[k]), .mem_rdata(mem_rdata)
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Apply one cycle of inputs, check all instances mid-cycle against the model, record grants.
    task automatic drive(input logic r, ir, input logic [AW-1:0] ia, input logic dr, dw,
                         input logic [AW-1:0] da, input logic [DW-1:0] wd,
                         input logic [BW-1:0] be, input logic [DW-1:0] rd);
        int g, o;
        rst = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dw;
        d_addr = da; d_wdata = wd; d_be = be; mem_rdata = rd;
        @(negedge clk);
        if (r) last_rst = cyc_n;
        eg_if = !r && ir && (!dr || wait_n == MAXS);
        eg_d  = !r && dr && !eg_if;
        for (int k = 0; k < NI; k++) begin
            g = cyc_n - (k + 1);
            o = (hist.exists(g) && last_rst < g && !r) ? hist[g] : -1;
            chk($sformatf("if_gnt[%0d]", k), if_gnt[k], eg_if);
            chk($sformatf("d_gnt[%0d]", k), d_gnt[k], eg_d);
            chk($sformatf("mem_en[%0d]", k), mem_en[k], eg_if | eg_d);
            chk($sformatf("mem_we[%0d]", k), mem_we[k], eg_d & dw);
            chk($sformatf("mem_addr[%0d]", k), mem_addr[k], eg_if ? ia : eg_d ? da : '0);
            chk($sformatf("mem_wdata[%0d]", k), mem_wdata[k], eg_d ? wd : '0);
            chk($sformatf("mem_be[%0d]", k), mem_be[k], eg_if ? {BW{1'b1}} : eg_d ? be : '0);
            chk($sformatf("if_rvalid[%0d]", k), if_rvalid[k], o == 0);
            chk($sformatf("d_rvalid[%0d]", k), d_rvalid[k], o == 1);
            chk($sformatf("if_rdata[%0d]", k), if_rdata[k], rd);
            chk($sformatf("d_rdata[%0d]", k), d_rdata[k], rd);
        end
        hist[cyc_n] = eg_if ? 0 : (eg_d && !dw) ? 1 : -1;
        wait_n = (r || !ir || eg_if) ? 0 : eg_d ? ((wait_n < MAXS) ? wait_n + 1 : MAXS) : wait_n;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, '0, 0, 0, '0, '0, '0, $urandom);
            tick();
        end
    endtask

    typedef struct {
        logic r, ir, dr, dw, ig, dg;
    } vec_t;
    vec_t tv [16];

    initial begin
        logic          pi, pd, rw, rr;
        logic [AW-1:0] ra, rda;
        logic [DW-1:0] rwd;
        logic [BW-1:0] rbe;
        tv = '{
            '{1,1,1,0, 0,0}, '{1,1,1,0, 0,0},
            '{0,1,1,0, 0,1}, '{0,1,1,0, 0,1}, '{0,1,1,0, 1,0},
            '{0,1,1,0, 0,1}, '{0,1,1,1, 0,1}, '{0,1,1,0, 1,0},
            '{0,1,1,0, 0,1}, '{0,0,1,0, 0,1}, '{0,1,1,0, 0,1},
            '{0,1,1,0, 0,1}, '{0,1,1,0, 1,0},
            '{0,1,0,0, 1,0}, '{0,0,1,1, 0,1}, '{0,0,0,0, 0,0}
        };
        rst = 1'b1; if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
        @(posedge clk);
        #1;

        // Vector table: reset gating, starvation guard D,D,F,D,D,F, streak clear, lone requesters.
        for (int i = 0; i < 16; i++) begin
            drive(tv[i].r, tv[i].ir, 32'h1000 + 4*i, tv[i].dr, tv[i].dw, 32'h2000 + 4*i,
                  32'hA000_0000 + i, 4'hF, $urandom);
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("tv%0d if_gnt[%0d]", i, k), if_gnt[k], tv[i].ig);
                chk($sformatf("tv%0d d_gnt[%0d]", i, k), d_gnt[k], tv[i].dg);
                chk($sformatf("tv%0d mem_en[%0d]", i, k), mem_en[k], tv[i].ig | tv[i].dg);
            end
            tick();
        end
        idle(4);

        // Single fetch, READ_LAT=1 instance.
        drive(0, 1, 32'h40, 0, 0, '0, '0, '0, '0);
        chk("fetch if_gnt", if_gnt[0], 1'b1);
        chk("fetch mem_addr", mem_addr[0], 32'h40);
        tick();
        drive(0, 0, '0, 0, 0, '0, '0, '0, 32'hDEADBEEF);
        chk("fetch if_rvalid", if_rvalid[0], 1'b1);
        chk("fetch if_rdata", if_rdata[0], 32'hDEADBEEF);
        chk("fetch d_rvalid", d_rvalid[0], 1'b0);
        tick();
        idle(4);

        // Store: fields pass through, never a response.
        drive(0, 0, '0, 1, 1, 32'h100, 32'h12345678, 4'b0011, '0);
        chk("store mem_we", mem_we[0], 1'b1);
        chk("store mem_addr", mem_addr[0], 32'h100);
        chk("store mem_wdata", mem_wdata[0], 32'h12345678);
        chk("store mem_be", mem_be[0], 4'b0011);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, '0, 0, 0, '0, '0, '0, $urandom);
            for (int k = 0; k < NI; k++) chk($sformatf("store no d_rvalid[%0d]", k), d_rvalid[k], 1'b0);
            tick();
        end

        // Interleaved F,D,F reads on the READ_LAT=3 instance.
        drive(0, 1, 32'h200, 0, 0, '0, '0, '0, '0); tick();
        drive(0, 0, '0, 1, 0, 32'h300, '0, 4'hF, '0); tick();
        drive(0, 1, 32'h204, 0, 0, '0, '0, '0, '0); tick();
        drive(0, 0, '0, 0, 0, '0, '0, '0, 32'h1111_0001);
        chk("ilv0 if_rvalid", if_rvalid[2], 1'b1);
        chk("ilv0 if_rdata", if_rdata[2], 32'h1111_0001);
        tick();
        drive(0, 0, '0, 0, 0, '0, '0, '0, 32'h2222_0002);
        chk("ilv1 d_rvalid", d_rvalid[2], 1'b1);
        chk("ilv1 if_rvalid", if_rvalid[2], 1'b0);
        chk("ilv1 d_rdata", d_rdata[2], 32'h2222_0002);
        tick();
        drive(0, 0, '0, 0, 0, '0, '0, '0, 32'h3333_0003);
        chk("ilv2 if_rvalid", if_rvalid[2], 1'b1);
        chk("ilv2 if_rdata", if_rdata[2], 32'h3333_0003);
        tick();
        idle(4);

        // Reset mid-flight on the READ_LAT=2 instance.
        drive(0, 0, '0, 1, 0, 32'h400, '0, 4'hF, '0); tick();
        drive(1, 0, '0, 0, 0, '0, '0, '0, '0); tick();
        drive(0, 0, '0, 0, 0, '0, '0, '0, 32'h5555_5555);
        chk("midrst d_rvalid", d_rvalid[1], 1'b0);
        tick();
        idle(4);

        // Random traffic with held requests and occasional reset.
        pi = 0; pd = 0; rw = 0; ra = '0; rda = '0; rwd = '0; rbe = '0;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 63) == 0);
            if (!pi || eg_if) begin pi = ($urandom_range(0, 2) != 0); ra = $urandom; end
            if (!pd || eg_d) begin
                pd = ($urandom_range(0, 2) != 0); rw = $urandom_range(0, 1);
                rda = $urandom; rwd = $urandom; rbe = $urandom_range(0, 15);
            end
            drive(rr, pi, ra, pd, rw, rda, rwd, rbe, $urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
